tcm_port_arbiter: RTL

TCM_PORT_ARBITER -- requirements
Module: tcm_port_arbiter

---
 rtl/tcm_port_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/tcm_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port synchronous-read TCM.
// Latency: grant is combinational in the request cycle; read data returns one cycle after grant.
// Backpressure: a losing requester holds req/payload until its gnt; data wins ties until fetch starves.
module tcm_port_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int STARVE_LIMIT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [15:0]       conflict_cnt
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    owner_e            owner_q, owner_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic [15:0]       conflict_cnt_q, conflict_cnt_d;
    logic              conflict;

    // Grant selection: data wins a conflict unless fetch has waited STARVE_LIMIT data grants.
    always_comb begin
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        conflict = i_req && d_req;
        if (!reset) begin
            if (conflict) begin
                if (starve_cnt_q == SW'(STARVE_LIMIT)) begin
                    i_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
            end else begin
                i_gnt = i_req;
                d_gnt = d_req;
            end
        end
    end

    // Memory command mux: granted port drives the memory, otherwise address/wdata hold and no write.
    always_comb begin
        mem_addr  = addr_q;
        mem_wr    = 4'b0000;
        mem_wdata = wdata_q;
        if (i_gnt) begin
            mem_addr = i_addr;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wr    = d_we;
            mem_wdata = d_wdata;
        end
    end

    // Response routing from the owner tag; rdata passes memory data through when valid, else holds.
    always_comb begin
        i_rvalid     = (owner_q == OWN_FETCH);
        d_rvalid     = (owner_q == OWN_DATA);
        i_rdata      = i_rvalid ? mem_rdata : i_rdata_q;
        d_rdata      = d_rvalid ? mem_rdata : d_rdata_q;
        conflict_cnt = conflict_cnt_q;
    end

    // Next-state: owner tag, starvation counter, held command, held read data, conflict counter.
    always_comb begin
        owner_d        = OWN_NONE;
        starve_cnt_d   = starve_cnt_q;
        addr_d         = mem_addr;
        wdata_d        = mem_wdata;
        i_rdata_d      = i_rdata;
        d_rdata_d      = d_rdata;
        conflict_cnt_d = conflict_cnt_q;

        if (i_gnt) begin
            owner_d = OWN_FETCH;
        end else if (d_gnt && (d_we == 4'b0000)) begin
            owner_d = OWN_DATA;
        end

        if (!i_req || i_gnt) begin
            starve_cnt_d = '0;
        end else if (d_gnt && (starve_cnt_q < SW'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end

        if (conflict && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    // State registers; reset squashes any outstanding read response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q        <= OWN_NONE;
            starve_cnt_q   <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
            conflict_cnt_q <= '0;
        end else begin
            owner_q        <= owner_d;
            starve_cnt_q   <= starve_cnt_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            i_rdata_q      <= i_rdata_d;
            d_rdata_q      <= d_rdata_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

endmodule
